// File: rtl/ahb3lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_pkg
//   Shared AHB3-Lite encodings and the local types used by the two-requester
//   DMA master arbiter.
//   Contents:
//     - HTRANS / HBURST / HRESP encodings
//     - slot_state_t : per-requester slot state (IDLE, PEND, DATA)
//     - owner_t      : bus owner encoding (NONE, R0, R1)
//     - is_transfer(): true for HTRANS values that start a real transfer
// ----------------------------------------------------------------------------
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] slot_state_t;
    localparam slot_state_t SLOT_IDLE = 2'd0;
    localparam slot_state_t SLOT_PEND = 2'd1;
    localparam slot_state_t SLOT_DATA = 2'd2;

    typedef logic [1:0] owner_t;
    localparam owner_t OWNER_NONE = 2'd0;
    localparam owner_t OWNER_R0   = 2'd1;
    localparam owner_t OWNER_R1   = 2'd2;

    // NONSEQ and SEQ carry data; IDLE and BUSY never do.
    function automatic logic is_transfer(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb3lite_dma_req_slot.sv
// ----------------------------------------------------------------------------
// ahb3lite_dma_req_slot
//   One requester-side slot: captures the requester's address phase and runs
//   the IDLE -> PEND -> DATA state machine that lets the requester see a
//   legal AHB3-Lite slave while the shared bus is arbitrated.
//   Ports:
//     clk_i, rst_n_i        clock, asynchronous active-low reset
//     hsel, htrans, haddr,
//     hwrite, hsize, hprot  requester address-phase signals
//     bus_hready, bus_hresp shared bus ready / response
//     is_addr_owner         this slot currently owns the bus address phase
//     hready, hresp         ready / response returned to the requester
//     accept                a transfer is accepted at the coming edge
//     pending               slot is waiting for or in its bus address phase
//     addr, write, size,
//     prot                  captured address-phase registers
// ----------------------------------------------------------------------------
module ahb3lite_dma_req_slot
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  hsel,
    input  logic [1:0]            htrans,
    input  logic [HADDR_SIZE-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [3:0]            hprot,
    input  logic                  bus_hready,
    input  logic                  bus_hresp,
    input  logic                  is_addr_owner,
    output logic                  hready,
    output logic                  hresp,
    output logic                  accept,
    output logic                  pending,
    output logic [HADDR_SIZE-1:0] addr,
    output logic                  write,
    output logic [2:0]            size,
    output logic [3:0]            prot
);

    slot_state_t state;

    // NOTE: defaults are assigned before the case so no path leaves hready
    // unassigned and no latch is inferred.
    always_comb begin
        hready = 1'b1;
        case (state)
            SLOT_IDLE: hready = 1'b1;
            SLOT_PEND: hready = 1'b0;
            SLOT_DATA: hready = bus_hready;
            default:   hready = 1'b1;
        endcase
    end

    assign hresp   = (state == SLOT_DATA) ? bus_hresp : HRESP_OKAY;
    assign pending = (state == SLOT_PEND);
    assign accept  = hsel && is_transfer(htrans) && hready;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= SLOT_IDLE;
        end else begin
            case (state)
                SLOT_IDLE: if (accept) state <= SLOT_PEND;
                SLOT_PEND: if (bus_hready && is_addr_owner) state <= SLOT_DATA;
                // A requester in DATA sees hready=1 at the same edge the bus
                // completes, so it may chain straight into a new transfer.
                SLOT_DATA: if (bus_hready) state <= accept ? SLOT_PEND : SLOT_IDLE;
                default:   state <= SLOT_IDLE;
            endcase
        end
    end

    // NOTE: the capture registers are reset too, so the bus never sees
    // X on address/control even though they are only used while owned.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr  <= '0;
            write <= 1'b0;
            size  <= '0;
            prot  <= '0;
        end else if (accept) begin
            addr  <= haddr;
            write <= hwrite;
            size  <= hsize;
            prot  <= hprot;
        end
    end

endmodule

// File: rtl/ahb3lite_dma_master_arb.sv
// ----------------------------------------------------------------------------
// ahb3lite_dma_master_arb
//   Merges two AHB3-Lite requester ports onto one AHB3-Lite master bus.
//   Each requester's address phase is parked in a slot; slots are granted to
//   the bus one single transfer at a time (round-robin or fixed priority).
//   Ports:
//     clk_i, rst_n_i                 clock, asynchronous active-low reset
//     rHSEL..rHTRANS                 requester address/data-phase inputs
//     rHRDATA, rHREADY, rHRESP       responses back to each requester
//     mHSEL..mHTRANS, mHWDATA        shared bus address/data-phase outputs
//     mHRDATA, mHREADY, mHRESP       shared bus responses
//     mHREADYOUT                     mirrors mHREADY
//   Parameters:
//     HADDR_SIZE, HDATA_SIZE         address / data widths
//     PRIORITY_MODE                  0 = round-robin, 1 = requester 0 wins
// ----------------------------------------------------------------------------
module ahb3lite_dma_master_arb
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE    = 32,
    parameter int HDATA_SIZE    = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,

    input  logic [1:0]                 rHSEL,
    input  logic [1:0][HADDR_SIZE-1:0] rHADDR,
    input  logic [1:0][HDATA_SIZE-1:0] rHWDATA,
    input  logic [1:0]                 rHWRITE,
    input  logic [1:0][2:0]            rHSIZE,
    input  logic [1:0][2:0]            rHBURST,
    input  logic [1:0][3:0]            rHPROT,
    input  logic [1:0][1:0]            rHTRANS,
    output logic [1:0][HDATA_SIZE-1:0] rHRDATA,
    output logic [1:0]                 rHREADY,
    output logic [1:0]                 rHRESP,

    output logic                       mHSEL,
    output logic [HADDR_SIZE-1:0]      mHADDR,
    output logic [HDATA_SIZE-1:0]      mHWDATA,
    input  logic [HDATA_SIZE-1:0]      mHRDATA,
    output logic                       mHWRITE,
    output logic [2:0]                 mHSIZE,
    output logic [2:0]                 mHBURST,
    output logic [3:0]                 mHPROT,
    output logic [1:0]                 mHTRANS,
    output logic                       mHREADYOUT,
    input  logic                       mHREADY,
    input  logic                       mHRESP
);

    owner_t addr_owner;
    owner_t data_owner;
    owner_t grant;
    logic   rr_favour_r1;

    logic [1:0]            accept;
    logic [1:0]            pending;
    logic [1:0]            cand;
    logic [HADDR_SIZE-1:0] slot_addr  [2];
    logic                  slot_write [2];
    logic [2:0]            slot_size  [2];
    logic [3:0]            slot_prot  [2];

    // Bursts are split into singles, so the requester burst type is unused.
    logic unused_hburst;
    assign unused_hburst = ^rHBURST;

    for (genvar g = 0; g < 2; g++) begin : g_slot
        localparam owner_t SLOT_ID = (g == 0) ? OWNER_R0 : OWNER_R1;

        ahb3lite_dma_req_slot #(
            .HADDR_SIZE (HADDR_SIZE)
        ) u_slot (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .hsel          (rHSEL[g]),
            .htrans        (rHTRANS[g]),
            .haddr         (rHADDR[g]),
            .hwrite        (rHWRITE[g]),
            .hsize         (rHSIZE[g]),
            .hprot         (rHPROT[g]),
            .bus_hready    (mHREADY),
            .bus_hresp     (mHRESP),
            .is_addr_owner (addr_owner == SLOT_ID),
            .hready        (rHREADY[g]),
            .hresp         (rHRESP[g]),
            .accept        (accept[g]),
            .pending       (pending[g]),
            .addr          (slot_addr[g]),
            .write         (slot_write[g]),
            .size          (slot_size[g]),
            .prot          (slot_prot[g])
        );

        // A slot accepted at this edge is already a candidate, which is what
        // gives the one-cycle accept-to-address-phase latency. A pending slot
        // that already owns the address phase is leaving for DATA.
        assign cand[g] = (pending[g] && (addr_owner != SLOT_ID)) || accept[g];

        assign rHRDATA[g] = mHRDATA;
    end

    always_comb begin
        grant = OWNER_NONE;
        if (cand == 2'b11) begin
            if (PRIORITY_MODE == 1 || !rr_favour_r1) grant = OWNER_R0;
            else                                     grant = OWNER_R1;
        end else if (cand[0]) begin
            grant = OWNER_R0;
        end else if (cand[1]) begin
            grant = OWNER_R1;
        end
    end

    // Owners only move when the bus completes a phase, so address/control
    // stay stable across slave wait states.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_owner   <= OWNER_NONE;
            data_owner   <= OWNER_NONE;
            rr_favour_r1 <= 1'b0;
        end else if (mHREADY) begin
            data_owner <= addr_owner;
            addr_owner <= grant;
            if (grant != OWNER_NONE) rr_favour_r1 <= (grant == OWNER_R0);
        end
    end

    logic addr_idx;
    logic data_idx;
    assign addr_idx = (addr_owner == OWNER_R1);
    assign data_idx = (data_owner == OWNER_R1);

    always_comb begin
        mHSEL   = 1'b0;
        mHTRANS = HTRANS_IDLE;
        mHADDR  = '0;
        mHWRITE = 1'b0;
        mHSIZE  = '0;
        mHPROT  = '0;
        if (addr_owner != OWNER_NONE) begin
            mHSEL   = 1'b1;
            mHTRANS = HTRANS_NONSEQ;
            mHADDR  = slot_addr[addr_idx];
            mHWRITE = slot_write[addr_idx];
            mHSIZE  = slot_size[addr_idx];
            mHPROT  = slot_prot[addr_idx];
        end
    end

    // The data owner's requester holds HWDATA while it is stalled in PEND
    // and throughout DATA, so a plain mux is enough.
    assign mHWDATA    = (data_owner != OWNER_NONE) ? rHWDATA[data_idx] : '0;
    assign mHBURST    = HBURST_SINGLE;
    assign mHREADYOUT = mHREADY;

endmodule

// File: tb/tb_ahb3lite_dma_master_arb.sv
// ----------------------------------------------------------------------------
// tb_ahb3lite_dma_master_arb
//   Directed bench for the two-requester AHB3-Lite master arbiter.
//   A round-robin instance runs a cycle-by-cycle vector table; a fixed-
//   priority instance shares the inputs (with its select gated) for the
//   priority comparison. Reset-in-flight is a hand-written sequence.
// ----------------------------------------------------------------------------
module tb_ahb3lite_dma_master_arb;
    import ahb3lite_pkg::*;

    localparam logic [1:0] I = HTRANS_IDLE;
    localparam logic [1:0] N = HTRANS_NONSEQ;

    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rHSEL = '0;
    logic [1:0]        fx_sel;
    logic              fx_en = 1'b0;
    logic [1:0][31:0]  rHADDR = '0;
    logic [1:0][31:0]  rHWDATA = '0;
    logic [1:0]        rHWRITE = '0;
    logic [1:0][2:0]   rHSIZE = {3'd2, 3'd2};
    logic [1:0][2:0]   rHBURST = '0;
    logic [1:0][3:0]   rHPROT = {4'd3, 4'd3};
    logic [1:0][1:0]   rHTRANS = '0;
    logic [31:0]       mHRDATA = 32'hDEADBEEF;
    logic              mHREADY = 1'b1;
    logic              mHRESP = 1'b0;

    assign fx_sel = rHSEL & {2{fx_en}};

    // Round-robin instance outputs
    logic [1:0][31:0] rr_rdata;
    logic [1:0]       rr_rdy, rr_resp;
    logic             rr_sel, rr_write, rr_readyout;
    logic [31:0]      rr_addr, rr_wdata;
    logic [2:0]       rr_size, rr_burst;
    logic [3:0]       rr_prot;
    logic [1:0]       rr_trans;

    // Fixed-priority instance outputs
    logic [1:0][31:0] fx_rdata;
    logic [1:0]       fx_rdy, fx_resp;
    logic             fx_hsel, fx_write, fx_readyout;
    logic [31:0]      fx_addr, fx_wdata;
    logic [2:0]       fx_size, fx_burst;
    logic [3:0]       fx_prot;
    logic [1:0]       fx_trans;

    ahb3lite_dma_master_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PRIORITY_MODE(0)) u_rr (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .rHSEL(rHSEL), .rHADDR(rHADDR), .rHWDATA(rHWDATA), .rHWRITE(rHWRITE),
        .rHSIZE(rHSIZE), .rHBURST(rHBURST), .rHPROT(rHPROT), .rHTRANS(rHTRANS),
        .rHRDATA(rr_rdata), .rHREADY(rr_rdy), .rHRESP(rr_resp),
        .mHSEL(rr_sel), .mHADDR(rr_addr), .mHWDATA(rr_wdata), .mHRDATA(mHRDATA),
        .mHWRITE(rr_write), .mHSIZE(rr_size), .mHBURST(rr_burst), .mHPROT(rr_prot),
        .mHTRANS(rr_trans), .mHREADYOUT(rr_readyout), .mHREADY(mHREADY), .mHRESP(mHRESP)
    );

    ahb3lite_dma_master_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PRIORITY_MODE(1)) u_fx (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .rHSEL(fx_sel), .rHADDR(rHADDR), .rHWDATA(rHWDATA), .rHWRITE(rHWRITE),
        .rHSIZE(rHSIZE), .rHBURST(rHBURST), .rHPROT(rHPROT), .rHTRANS(rHTRANS),
        .rHRDATA(fx_rdata), .rHREADY(fx_rdy), .rHRESP(fx_resp),
        .mHSEL(fx_hsel), .mHADDR(fx_addr), .mHWDATA(fx_wdata), .mHRDATA(mHRDATA),
        .mHWRITE(fx_write), .mHSIZE(fx_size), .mHBURST(fx_burst), .mHPROT(fx_prot),
        .mHTRANS(fx_trans), .mHREADYOUT(fx_readyout), .mHREADY(mHREADY), .mHRESP(mHRESP)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  tr0, tr1;
        logic [31:0] a0, a1;
        logic [1:0]  wr;
        logic [31:0] wd0, wd1;
        logic        mrdy, mresp;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic [31:0] e_wdata;
        logic [1:0]  e_rdy, e_resp;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] sel, input logic [1:0] tr0, input logic [1:0] tr1,
        input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] wr,
        input logic [31:0] wd0, input logic [31:0] wd1, input logic mrdy, input logic mresp,
        input logic [1:0] e_trans, input logic [31:0] e_addr, input logic e_write,
        input logic [31:0] e_wdata, input logic [1:0] e_rdy, input logic [1:0] e_resp);
        vec_t v;
        v.sel = sel; v.tr0 = tr0; v.tr1 = tr1; v.a0 = a0; v.a1 = a1; v.wr = wr;
        v.wd0 = wd0; v.wd1 = wd1; v.mrdy = mrdy; v.mresp = mresp;
        v.e_trans = e_trans; v.e_addr = e_addr; v.e_write = e_write;
        v.e_wdata = e_wdata; v.e_rdy = e_rdy; v.e_resp = e_resp;
        return v;
    endfunction

    task automatic drive_idle();
        rHSEL = '0; rHTRANS = '0; rHADDR = '0; rHWRITE = '0; rHWDATA = '0;
        mHREADY = 1'b1; mHRESP = 1'b0;
    endtask

    initial begin
        // Each row: inputs for one cycle, then the outputs expected in that
        // same cycle (before the edge that consumes the inputs).
        //                 sel    tr0 tr1 a0        a1        wr     wd0     wd1     rdy resp| trans addr     wr  wdata   rdy    resp
        // Idle after reset
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        // Simultaneous writes, r0 first (pointer favours r0 after reset)
        vecs.push_back(mk(2'b11, N, N, 32'h10,   32'h20,   2'b11, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'hA,  32'hB,  1, 0, N, 32'h10,  1, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'hA,  32'hB,  1, 0, N, 32'h20,  1, 32'hA, 2'b01, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'hB,  1, 0, I, 32'h0,   0, 32'hB, 2'b11, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        // r1 read in DATA with 3 wait states while r0 sits in PEND
        vecs.push_back(mk(2'b10, I, N, 32'h0,    32'h200,  2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        vecs.push_back(mk(2'b01, N, I, 32'h300,  32'h0,    2'b00, 32'h0,  32'h0,  1, 0, N, 32'h200, 0, 32'h0, 2'b01, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  0, 0, N, 32'h300, 0, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'hFFF,  32'h0,    2'b00, 32'h0,  32'h0,  0, 0, N, 32'h300, 0, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  0, 0, N, 32'h300, 0, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, N, 32'h300, 0, 32'h0, 2'b10, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        // r0 read answered with a two-cycle ERROR
        vecs.push_back(mk(2'b01, N, I, 32'h400,  32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, N, 32'h400, 0, 32'h0, 2'b10, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  0, 1, I, 32'h0,   0, 32'h0, 2'b10, 2'b01));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 1, I, 32'h0,   0, 32'h0, 2'b11, 2'b01));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        // Single r0 read of 0x100, zero-wait slave
        vecs.push_back(mk(2'b01, N, I, 32'h100,  32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, N, 32'h100, 0, 32'h0, 2'b10, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));
        vecs.push_back(mk(2'b00, I, I, 32'h0,    32'h0,    2'b00, 32'h0,  32'h0,  1, 0, I, 32'h0,   0, 32'h0, 2'b11, 2'b00));

        // Reset state is visible while reset is still asserted
        #1;
        check("reset trans", 32'(rr_trans), 32'(HTRANS_IDLE));
        check("reset hsel", 32'(rr_sel), 32'd0);
        check("reset haddr", rr_addr, 32'h0);
        check("reset hwdata", rr_wdata, 32'h0);
        check("reset rhready", 32'(rr_rdy), 32'h3);
        check("reset rhresp", 32'(rr_resp), 32'h0);
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rHSEL      = vecs[i].sel;
            rHTRANS[0] = vecs[i].tr0;
            rHTRANS[1] = vecs[i].tr1;
            rHADDR[0]  = vecs[i].a0;
            rHADDR[1]  = vecs[i].a1;
            rHWRITE    = vecs[i].wr;
            rHWDATA[0] = vecs[i].wd0;
            rHWDATA[1] = vecs[i].wd1;
            mHREADY    = vecs[i].mrdy;
            mHRESP     = vecs[i].mresp;
            #1;
            check($sformatf("v%0d mhtrans", i), 32'(rr_trans), 32'(vecs[i].e_trans));
            check($sformatf("v%0d mhsel", i), 32'(rr_sel), 32'(vecs[i].e_trans == N));
            check($sformatf("v%0d mhaddr", i), rr_addr, vecs[i].e_addr);
            check($sformatf("v%0d mhwdata", i), rr_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d rhready", i), 32'(rr_rdy), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d rhresp", i), 32'(rr_resp), 32'(vecs[i].e_resp));
            check($sformatf("v%0d mhreadyout", i), 32'(rr_readyout), 32'(vecs[i].mrdy));
            if (vecs[i].e_trans == N) begin
                check($sformatf("v%0d mhwrite", i), 32'(rr_write), 32'(vecs[i].e_write));
                check($sformatf("v%0d mhsize", i), 32'(rr_size), 32'd2);
                check($sformatf("v%0d mhprot", i), 32'(rr_prot), 32'd3);
            end
        end
        check("rhrdata r0", rr_rdata[0], 32'hDEADBEEF);
        check("rhrdata r1", rr_rdata[1], 32'hDEADBEEF);
        check("mhburst", 32'(rr_burst), 32'(HBURST_SINGLE));

        // Priority: the round-robin pointer now favours r1 (r0 was granted
        // last); the fixed instance always serves r0 first.
        @(negedge clk);
        fx_en = 1'b1;
        rHSEL = 2'b11; rHTRANS[0] = N; rHTRANS[1] = N;
        rHADDR[0] = 32'h50; rHADDR[1] = 32'h60;
        @(negedge clk);
        drive_idle();
        #1;
        check("rr first addr", rr_addr, 32'h60);
        check("fx first addr", fx_addr, 32'h50);
        @(negedge clk);
        #1;
        check("rr second addr", rr_addr, 32'h50);
        check("fx second addr", fx_addr, 32'h60);
        check("fx second trans", 32'(fx_trans), 32'(N));
        repeat (3) @(negedge clk);
        #1;
        check("rr idle after prio", 32'(rr_trans), 32'(I));
        check("fx idle after prio", 32'(fx_trans), 32'(I));
        fx_en = 1'b0;

        // Reset while r1 is pending in its bus address phase
        @(negedge clk);
        rHSEL = 2'b10; rHTRANS[1] = N; rHADDR[1] = 32'h500;
        @(negedge clk);
        drive_idle();
        mHREADY = 1'b0;
        #1;
        check("pre-reset addr", rr_addr, 32'h500);
        check("pre-reset rhready", 32'(rr_rdy), 32'h1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async reset trans", 32'(rr_trans), 32'(I));
        check("async reset hsel", 32'(rr_sel), 32'd0);
        check("async reset haddr", rr_addr, 32'h0);
        check("async reset rhready", 32'(rr_rdy), 32'h3);
        @(negedge clk);
        mHREADY = 1'b1;
        rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-reset c%0d trans", c), 32'(rr_trans), 32'(I));
            check($sformatf("post-reset c%0d rhready", c), 32'(rr_rdy), 32'h3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
